pixel_gen_layered: RTL
======================

// Module: pixel_gen_layered
// PURPOSE
//  Parametrised successor of the single-box pixel generator for the flappy-bird VGA path. Renders sky,
//  ground, NUM_PIPES pipes and the bird. Layer priority is bird > pipe > ground > sky.
//  Owns the game display FSM: IDLE start box, PLAY scene, HIT red flash. Flags bird/pipe/ground collision.
//  Sits between the VGA sync counter (pixel_x/y, video_on) and the RGB output pins.
// PARAMETERS
//  NUM_PIPES    3    number of pipe channels (1..8)
//  PIPE_W       60   pipe width in pixels
//  GAP_H        120  vertical opening of each pipe in pixels
//  BIRD_SIZE    16   bird square edge in pixels
//  GROUND_Y     440  first ground row; rows >= GROUND_Y draw ground
//  H_VIS        640  visible width;  V_VIS  480  visible height
//  FLASH_FRAMES 30   frames spent in HIT before returning to IDLE
// PORTS
//  clk_div      in   1              pixel clock
//  reset        in   1              asynchronous, active-high
//  start        in   1              level; IDLE->PLAY when sampled high at a frame start
//  video_on     in   1              visible-area qualifier from sync counter
//  pixel_x      in   10             current column
//  pixel_y      in   10             current row
//  bird_x       in   10             bird top-left column
//  bird_y       in   10             bird top-left row
//  pipe_x       in   10*NUM_PIPES   packed pipe left columns, pipe i at [10*i+:10]
//  pipe_gap_y   in   10*NUM_PIPES   packed gap top rows, pipe i at [10*i+:10]
//  red          out  4              colour channel (registered)
//  green        out  4              colour channel (registered)
//  blue         out  4              colour channel (registered)
//  collision    out  1              one-cycle pulse at the frame end of a frame that had a collision in PLAY
//  state        out  2              current FSM state (debug/score logic)
// BEHAVIOUR
//  - Reset: red/green/blue=0, collision=0, state=IDLE, shadow coords=0, flash counter=0, sticky flag=0.
//  - frame_start = (pixel_x==0 && pixel_y==0); frame_end = (pixel_x==H_VIS-1 && pixel_y==V_VIS-1).
//  - Shadow regs: bird_x/y, pipe_x, pipe_gap_y latched on frame_start only; mid-frame input changes take
//    effect next frame (no tearing). Shadows are used by both rendering and collision.
//  - Pipeline latency 2 cycles. S1 registers the hit flags bird_hit, pipe_hit[i], ground_hit and
//    video_on. S2 priority-muxes the flags to RGB. RGB is 0 whenever the S1-delayed video_on=0.
//  - Width rule: all right/bottom edges are computed in 11 bits (x+PIPE_W, gap+GAP_H, y+BIRD_SIZE),
//    so objects near 1023 never wrap. Rectangle hit = lo <= p < lo+size (half-open).
//  - pipe_hit[i] = x in [px,px+PIPE_W) && (y < gap || y >= gap+GAP_H) && y < GROUND_Y.
//  - Colours: sky 4'h4/4'hA/4'hF, ground 4'h8/4'h5/4'h2, pipe 4'h0/4'hC/4'h0, bird 4'hF/4'hF/4'h0,
//    start box 4'hF/4'hF/4'hF, HIT flash 4'hF/4'h0/4'h0.
//  - FSM:
//    IDLE: sky plus white box x in [100,540], y in [80,400] (inclusive). At frame_start with start=1 -> PLAY.
//    PLAY: full layered scene. At frame_end: if sticky=1, pulse collision, clear sticky, flash counter=0,
//          go to HIT; else stay in PLAY.
//    HIT: scene drawn every frame. In even frames, bird and pipe pixels are drawn as flash red.
//         The counter increments at each frame_end. At frame_end with count==FLASH_FRAMES-1 -> IDLE.
//  - sticky sets in PLAY when S1 bird_hit && video_on && (any pipe_hit || ground_hit).
//  - Simultaneous frame_end and a collision pixel: the pixel is not visible (the corner is not overlapped),
//    so the same-cycle case is defined to count toward the current frame.
//  - start is ignored outside IDLE. Reset mid-frame: the FSM returns to IDLE and outputs clear at once.
//  - Pipes with pipe_x >= H_VIS are simply off-screen; they are not an error.
// STRUCTURE
//  - Shared package pixel_gen_pkg: state encoding (IDLE=2'd0, PLAY=2'd1, HIT=2'd2), the colour constants
//    above, and the start-box bounds.
//  - One sub-module, pixel_rect_hit: combinational 11-bit half-open rectangle test. It is instantiated
//    once for the bird, per pipe (top/bottom halves), and once for the ground.
// TESTING
//  1. Reset, then start=0 for 2 frames -> state=IDLE; (320,240) is white 4'hF; (10,10) is sky;
//     RGB at output 2 cycles after the pixel.
//  2. start=1 at frame_start; bird (50,200); pipe0 x=300, gap=150 -> state=PLAY; (310,100) green pipe;
//     (310,200) sky; (55,205) yellow; (10,450) ground.
//  3. Change bird_x mid-frame (at y=240) -> render is unchanged until the next frame_start.
//  4. Bird (300,100) overlapping pipe0 top -> collision pulses exactly 1 cycle at frame_end; state=HIT.
//     Bird/pipes flash red on even frames. state=IDLE after 30 frames.
//  5. pipe_x=1000, gap=1015 and bird_y=1020 -> no wrap artefacts; column 0 shows no pipe or bird.
//  6. Assert reset while in HIT mid-frame -> RGB=0, collision=0, state=IDLE on the next edge.

Source files
------------

// File: rtl/pixel_gen_layered_pkg.sv
// Shared types and constants for the layered flappy-bird pixel generator:
// display FSM encoding, palette and the IDLE start-box bounds.
package pixel_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t COL_BLACK  = 12'h000;
  localparam rgb_t COL_SKY    = 12'h4AF;
  localparam rgb_t COL_GROUND = 12'h852;
  localparam rgb_t COL_PIPE   = 12'h0C0;
  localparam rgb_t COL_BIRD   = 12'hFF0;
  localparam rgb_t COL_BOX    = 12'hFFF;
  localparam rgb_t COL_FLASH  = 12'hF00;

  // Start box, inclusive on all four edges
  localparam int BOX_X0 = 100;
  localparam int BOX_X1 = 540;
  localparam int BOX_Y0 = 80;
  localparam int BOX_Y1 = 400;

endpackage

// File: rtl/pixel_gen_layered_if.sv
// Pixel-stream bundle between the VGA sync/game logic and the layered pixel generator.
interface pixel_gen_layered_if #(
  parameter int NUM_PIPES = 3
);
  logic                    start;
  logic                    video_on;
  logic [9:0]              pixel_x;
  logic [9:0]              pixel_y;
  logic [9:0]              bird_x;
  logic [9:0]              bird_y;
  logic [10*NUM_PIPES-1:0] pipe_x;
  logic [10*NUM_PIPES-1:0] pipe_gap_y;
  logic [3:0]              red;
  logic [3:0]              green;
  logic [3:0]              blue;
  logic                    collision;
  logic [1:0]              state;

  modport master (
    output start, video_on, pixel_x, pixel_y, bird_x, bird_y, pipe_x, pipe_gap_y,
    input  red, green, blue, collision, state
  );

  modport slave (
    input  start, video_on, pixel_x, pixel_y, bird_x, bird_y, pipe_x, pipe_gap_y,
    output red, green, blue, collision, state
  );
endinterface

// File: rtl/pixel_gen_layered_rect_hit.sv
// Half-open rectangle test, lo <= p < hi on both axes. Bounds are 11 bits so
// objects whose right/bottom edge passes 1023 never wrap back onto column/row 0.
module pixel_rect_hit (
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [10:0] x_lo,
  input  logic [10:0] x_hi,
  input  logic [10:0] y_lo,
  input  logic [10:0] y_hi,
  output logic        hit
);
  logic [10:0] x_e;
  logic [10:0] y_e;

  assign x_e = {1'b0, x};
  assign y_e = {1'b0, y};
  assign hit = (x_e >= x_lo) && (x_e < x_hi) && (y_e >= y_lo) && (y_e < y_hi);
endmodule

// File: rtl/pixel_gen_layered.sv
// Layered sky/ground/pipes/bird renderer with IDLE/PLAY/HIT display FSM and
// per-frame collision flag. Two-cycle pipeline: hit flags, then colour mux.
module pixel_gen_layered
  import pixel_gen_pkg::*;
#(
  parameter int NUM_PIPES    = 3,
  parameter int PIPE_W       = 60,
  parameter int GAP_H        = 120,
  parameter int BIRD_SIZE    = 16,
  parameter int GROUND_Y     = 440,
  parameter int H_VIS        = 640,
  parameter int V_VIS        = 480,
  parameter int FLASH_FRAMES = 30
) (
  input  logic               clk_div,
  input  logic               reset,
  pixel_gen_layered_if.slave bus
);
  localparam int CW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  logic frame_start;
  logic frame_end;

  assign frame_start = (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'd0);
  assign frame_end   = (bus.pixel_x == 10'(H_VIS - 1)) && (bus.pixel_y == 10'(V_VIS - 1));

  logic [9:0]              sh_bird_x, sh_bird_y;
  logic [10*NUM_PIPES-1:0] sh_pipe_x, sh_gap_y;

  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) begin
      sh_bird_x <= '0;
      sh_bird_y <= '0;
      sh_pipe_x <= '0;
      sh_gap_y  <= '0;
    end else if (frame_start) begin
      sh_bird_x <= bus.bird_x;
      sh_bird_y <= bus.bird_y;
      sh_pipe_x <= bus.pipe_x;
      sh_gap_y  <= bus.pipe_gap_y;
    end
  end

  // Pixel (0,0) already belongs to the new frame, so it sees the values being latched
  logic [9:0]              eff_bird_x, eff_bird_y;
  logic [10*NUM_PIPES-1:0] eff_pipe_x, eff_gap_y;

  assign eff_bird_x = frame_start ? bus.bird_x     : sh_bird_x;
  assign eff_bird_y = frame_start ? bus.bird_y     : sh_bird_y;
  assign eff_pipe_x = frame_start ? bus.pipe_x     : sh_pipe_x;
  assign eff_gap_y  = frame_start ? bus.pipe_gap_y : sh_gap_y;

  logic                 bird_c;
  logic                 ground_c;
  logic                 box_c;
  logic [NUM_PIPES-1:0] pipe_c;

  pixel_rect_hit u_bird (
    .x    (bus.pixel_x),
    .y    (bus.pixel_y),
    .x_lo ({1'b0, eff_bird_x}),
    .x_hi ({1'b0, eff_bird_x} + 11'(BIRD_SIZE)),
    .y_lo ({1'b0, eff_bird_y}),
    .y_hi ({1'b0, eff_bird_y} + 11'(BIRD_SIZE)),
    .hit  (bird_c)
  );

  pixel_rect_hit u_ground (
    .x    (bus.pixel_x),
    .y    (bus.pixel_y),
    .x_lo (11'd0),
    .x_hi (11'h7FF),
    .y_lo (11'(GROUND_Y)),
    .y_hi (11'h7FF),
    .hit  (ground_c)
  );

  for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
    logic [10:0] px_lo, px_hi, gap_lo, gap_hi, top_hi;
    logic        hit_top, hit_bot;

    assign px_lo  = {1'b0, eff_pipe_x[10*gi +: 10]};
    assign px_hi  = px_lo + 11'(PIPE_W);
    assign gap_lo = {1'b0, eff_gap_y[10*gi +: 10]};
    assign gap_hi = gap_lo + 11'(GAP_H);
    // Top half stops at the ground even if the gap starts below it
    assign top_hi = (gap_lo < 11'(GROUND_Y)) ? gap_lo : 11'(GROUND_Y);

    pixel_rect_hit u_top (
      .x    (bus.pixel_x),
      .y    (bus.pixel_y),
      .x_lo (px_lo),
      .x_hi (px_hi),
      .y_lo (11'd0),
      .y_hi (top_hi),
      .hit  (hit_top)
    );

    pixel_rect_hit u_bot (
      .x    (bus.pixel_x),
      .y    (bus.pixel_y),
      .x_lo (px_lo),
      .x_hi (px_hi),
      .y_lo (gap_hi),
      .y_hi (11'(GROUND_Y)),
      .hit  (hit_bot)
    );

    assign pipe_c[gi] = hit_top | hit_bot;
  end

  assign box_c = (bus.pixel_x >= 10'(BOX_X0)) && (bus.pixel_x <= 10'(BOX_X1)) &&
                 (bus.pixel_y >= 10'(BOX_Y0)) && (bus.pixel_y <= 10'(BOX_Y1));

  state_t         state_q;
  logic [CW-1:0]  flash_cnt;
  logic           sticky;
  logic           collision_q;

  logic                 bird_s1, ground_s1, vid_s1, box_s1, flash_s1;
  logic [NUM_PIPES-1:0] pipe_s1;
  state_t               state_s1;

  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) begin
      bird_s1   <= 1'b0;
      pipe_s1   <= '0;
      ground_s1 <= 1'b0;
      vid_s1    <= 1'b0;
      box_s1    <= 1'b0;
      flash_s1  <= 1'b0;
      state_s1  <= ST_IDLE;
    end else begin
      bird_s1   <= bird_c;
      pipe_s1   <= pipe_c;
      ground_s1 <= ground_c;
      vid_s1    <= bus.video_on;
      box_s1    <= box_c;
      flash_s1  <= (state_q == ST_HIT) && !flash_cnt[0];
      state_s1  <= state_q;
    end
  end

  rgb_t col_c;
  rgb_t rgb_q;

  always_comb begin
    col_c = COL_BLACK;
    if (vid_s1) begin
      if (state_s1 == ST_PLAY || state_s1 == ST_HIT) begin
        if (bird_s1)        col_c = flash_s1 ? COL_FLASH : COL_BIRD;
        else if (|pipe_s1)  col_c = flash_s1 ? COL_FLASH : COL_PIPE;
        else if (ground_s1) col_c = COL_GROUND;
        else                col_c = COL_SKY;
      end else begin
        col_c = box_s1 ? COL_BOX : COL_SKY;
      end
    end
  end

  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) rgb_q <= COL_BLACK;
    else       rgb_q <= col_c;
  end

  // A hit on the pixel just before frame_end still counts toward this frame
  logic hit_now;
  assign hit_now = vid_s1 && bird_s1 && ((|pipe_s1) || ground_s1);

  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      flash_cnt   <= '0;
      sticky      <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      collision_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sticky <= 1'b0;
          if (frame_start && bus.start) state_q <= ST_PLAY;
        end
        ST_PLAY: begin
          if (frame_end && (sticky || hit_now)) begin
            collision_q <= 1'b1;
            sticky      <= 1'b0;
            flash_cnt   <= '0;
            state_q     <= ST_HIT;
          end else if (hit_now) begin
            sticky <= 1'b1;
          end
        end
        ST_HIT: begin
          if (frame_end) begin
            if (flash_cnt == CW'(FLASH_FRAMES - 1)) begin
              flash_cnt <= '0;
              state_q   <= ST_IDLE;
            end else begin
              flash_cnt <= flash_cnt + CW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.red       = rgb_q.r;
  assign bus.green     = rgb_q.g;
  assign bus.blue      = rgb_q.b;
  assign bus.collision = collision_q;
  assign bus.state     = state_q;

endmodule
